bcd_updown_counter_ndig: RTL and testbench

- Parametrised multi-digit BCD up/down counter; successor to the single-digit up/down counter.
- Cascades DIGITS decimal digits with internal digit-to-digit carry/borrow.
- Adds parallel load, a terminal-count output and a registered wrap pulse.
- Drives the seven-segment display path (one nibble per digit) and can chain to further counters through tc.

---
 rtl/bcd_updown_counter_ndig_if.sv | 16 +
 rtl/bcd_updown_counter_ndig.sv | 104 ++++++++++
 tb/tb_bcd_updown_counter_ndig.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bcd_updown_counter_ndig_if.sv
// Control/data bundle for the multi-digit BCD up/down counter.
// The master drives the strobes and load value; the counter (slave) returns the count and flags.
interface bcd_updown_counter_ndig_if #(
    parameter int DIGITS = 4
);
    logic                  En;
    logic                  Ud;
    logic                  Ld;
    logic [4*DIGITS-1:0]   Din;
    logic [4*DIGITS-1:0]   cnt;
    logic                  tc;
    logic                  wrap;

    modport master (output En, Ud, Ld, Din, input cnt, tc, wrap);
    modport slave  (input En, Ud, Ld, Din, output cnt, tc, wrap);
endinterface

// File: rtl/bcd_updown_counter_ndig.sv
// Parametrised DIGITS-wide BCD up/down counter with parallel load, terminal count and wrap pulse.
// Define BCD_CNT_SATURATE_EN to saturate at 0 / max instead of wrapping.
module bcd_updown_counter_ndig #(
    parameter int DIGITS    = 4,
    parameter bit STEP_HOLD = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    bcd_updown_counter_ndig_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_nxt;
    logic [W-1:0] cnt_step;
    logic [W-1:0] din_clamp;
    logic         en_q;
    logic         wrap_q;
    logic         wrap_nxt;
    logic         all9;
    logic         all0;
    logic         at_lim;
    logic         step;

    // Digit i steps only while every lower digit sits at its limit (ripple carry/borrow).
    always_comb begin
        logic       carry;
        logic [3:0] d;
        carry     = 1'b1;
        cnt_step  = cnt_q;
        din_clamp = '0;
        all9      = 1'b1;
        all0      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = cnt_q[4*i +: 4];
            if (carry) begin
                if (bus.Ud)
                    cnt_step[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                else
                    cnt_step[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
            end
            carry = carry & (bus.Ud ? (d == 4'd9) : (d == 4'd0));
            all9  = all9 & (d == 4'd9);
            all0  = all0 & (d == 4'd0);
            din_clamp[4*i +: 4] = (bus.Din[4*i +: 4] > 4'd9) ? 4'd9 : bus.Din[4*i +: 4];
        end
    end

    assign at_lim = bus.Ud ? all9 : all0;
    assign step   = bus.En & ~bus.Ld & (STEP_HOLD ? ~en_q : 1'b1);

`ifdef BCD_CNT_SATURATE_EN
    logic nxt9;
    logic nxt0;

    always_comb begin
        nxt9 = 1'b1;
        nxt0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            nxt9 = nxt9 & (cnt_step[4*i +: 4] == 4'd9);
            nxt0 = nxt0 & (cnt_step[4*i +: 4] == 4'd0);
        end
    end

    // At the limit the step is suppressed; the pulse marks only the arrival step.
    always_comb begin
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;
        if (bus.Ld) begin
            cnt_nxt = din_clamp;
        end else if (step && !at_lim) begin
            cnt_nxt  = cnt_step;
            wrap_nxt = bus.Ud ? nxt9 : nxt0;
        end
    end
`else
    always_comb begin
        cnt_nxt  = cnt_q;
        wrap_nxt = 1'b0;
        if (bus.Ld) begin
            cnt_nxt = din_clamp;
        end else if (step) begin
            cnt_nxt  = cnt_step;
            wrap_nxt = at_lim;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_nxt;
            wrap_q <= wrap_nxt;
            en_q   <= bus.En;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.wrap = wrap_q;
    assign bus.tc   = bus.En & at_lim;
endmodule

// File: tb/tb_bcd_updown_counter_ndig.sv
// Self-checking bench: two 2-digit counters (free-running and single-step) against an integer model.
module tb_bcd_updown_counter_ndig;
    localparam int D    = 2;
    localparam int MAXV = 99;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_updown_counter_ndig_if #(.DIGITS(D)) bus ();
    bcd_updown_counter_ndig_if #(.DIGITS(D)) bus_sh ();

    assign bus_sh.En  = bus.En;
    assign bus_sh.Ud  = bus.Ud;
    assign bus_sh.Ld  = bus.Ld;
    assign bus_sh.Din = bus.Din;

    bcd_updown_counter_ndig #(.DIGITS(D), .STEP_HOLD(1'b0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bcd_updown_counter_ndig #(.DIGITS(D), .STEP_HOLD(1'b1)) u_dut_sh (
        .clk (clk),
        .rst (rst),
        .bus (bus_sh)
    );

    int errors = 0;
    int checks = 0;
    int m_v, m_sh_v;
    bit m_w, m_sh_w, m_enq;

    task automatic check(input string tag, input string what, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s: observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int load_val(input logic [7:0] din);
        int hi = int'(din[7:4]);
        int lo = int'(din[3:0]);
        if (hi > 9) hi = 9;
        if (lo > 9) lo = 9;
        return hi * 10 + lo;
    endfunction

    function automatic void model_next(input int v, input bit stp, input bit ud, input bit ld,
                                       input logic [7:0] din, output int nv, output bit nw);
        nv = v;
        nw = 1'b0;
        if (ld) begin
            nv = load_val(din);
        end else if (stp) begin
`ifdef BCD_CNT_SATURATE_EN
            if (ud) begin
                if (v < MAXV) begin
                    nv = v + 1;
                    nw = (nv == MAXV);
                end
            end else if (v > 0) begin
                nv = v - 1;
                nw = (nv == 0);
            end
`else
            if (ud) begin
                nv = (v == MAXV) ? 0 : v + 1;
                nw = (v == MAXV);
            end else begin
                nv = (v == 0) ? MAXV : v - 1;
                nw = (v == 0);
            end
`endif
        end
    endfunction

    task automatic step(input bit en, input bit ud, input bit ld, input logic [7:0] din,
                        input string tag);
        int nv;
        bit nw;
        bus.En  = en;
        bus.Ud  = ud;
        bus.Ld  = ld;
        bus.Din = din;
        #1;
        check(tag, "tc", 32'(bus.tc), 32'(en & (ud ? (m_v == MAXV) : (m_v == 0))));
        check(tag, "tc_sh", 32'(bus_sh.tc), 32'(en & (ud ? (m_sh_v == MAXV) : (m_sh_v == 0))));
        @(posedge clk);
        model_next(m_v, en, ud, ld, din, nv, nw);
        m_v = nv;
        m_w = nw;
        model_next(m_sh_v, en & ~m_enq, ud, ld, din, nv, nw);
        m_sh_v = nv;
        m_sh_w = nw;
        m_enq  = en;
        #1;
        check(tag, "cnt", 32'(bus.cnt), 32'(to_bcd(m_v)));
        check(tag, "wrap", 32'(bus.wrap), 32'(m_w));
        check(tag, "cnt_sh", 32'(bus_sh.cnt), 32'(to_bcd(m_sh_v)));
        check(tag, "wrap_sh", 32'(bus_sh.wrap), 32'(m_sh_w));
    endtask

    task automatic model_reset();
        m_v    = 0;
        m_sh_v = 0;
        m_w    = 1'b0;
        m_sh_w = 1'b0;
        m_enq  = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        bus.En  = 1'b0;
        bus.Ud  = 1'b0;
        bus.Ld  = 1'b0;
        bus.Din = '0;
        model_reset();
        #1;
        check("reset", "cnt", 32'(bus.cnt), 32'h0);
        check("reset", "wrap", 32'(bus.wrap), 32'h0);
        bus.En = 1'b1;
        #1;
        check("reset", "tc_down", 32'(bus.tc), 32'h1);
        bus.Ud = 1'b1;
        #1;
        check("reset", "tc_up", 32'(bus.tc), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", "cnt", 32'(bus.cnt), 32'h0);
        rst = 1'b1;

        // Plain up count through the 09 -> 10 carry; single-step twin sees En held high.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 8'h00, "t1_up");
        check("t1_final", "cnt", 32'(bus.cnt), 32'h12);
        check("t1_final", "cnt_sh", 32'(bus_sh.cnt), 32'h01);

        step(1'b0, 1'b1, 1'b1, 8'h98, "t2_load");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h00, "t2_up");
        step(1'b1, 1'b0, 1'b1, 8'h01, "t2_load1");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, "t2_down");

        step(1'b0, 1'b1, 1'b1, 8'h3C, "t3_clamp");
        check("t3_clamp", "direct", 32'(bus.cnt), 32'h39);
        step(1'b1, 1'b1, 1'b1, 8'h21, "t3_ld_wins");
        check("t3_ld_wins", "direct", 32'(bus.cnt), 32'h21);
        step(1'b0, 1'b1, 1'b1, 8'hF7, "t3_clamp_hi");

        step(1'b0, 1'b1, 1'b1, 8'h45, "t4_load");
        step(1'b1, 1'b1, 1'b0, 8'h00, "t4_up");
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        check("t4_async", "cnt", 32'(bus.cnt), 32'h0);
        check("t4_async", "cnt_sh", 32'(bus_sh.cnt), 32'h0);
        check("t4_async", "wrap", 32'(bus.wrap), 32'h0);
        #2;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0, 8'h00, "t4_after");
        check("t4_after", "direct", 32'(bus.cnt), 32'h01);

        step(1'b0, 1'b1, 1'b1, 8'h50, "t5_load");
        for (int i = 0; i < 4; i++) step(1'b1, i[0], 1'b0, 8'h00, "t5_toggle");
        check("t5_toggle", "direct", 32'(bus.cnt), 32'h50);
        for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b0, 8'h00, "t5_hold");

        step(1'b0, 1'b1, 1'b1, 8'h97, "t6_load");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'h00, "t6_up");
        step(1'b0, 1'b0, 1'b1, 8'h02, "t6_load_lo");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, "t6_down");
        for (int i = 0; i < 6; i++) step(i[0], 1'b1, 1'b0, 8'h00, "t6_pulse_en");

        for (int i = 0; i < 400; i++) begin
            bit          en = ($urandom_range(0, 3) != 0);
            bit          ud = $urandom_range(0, 1) != 0;
            bit          ld = ($urandom_range(0, 15) == 0);
            logic [7:0]  din = 8'($urandom);
            if ($urandom_range(0, 3) == 0 && ld) din = ($urandom_range(0, 1) != 0) ? 8'h99 : 8'h00;
            step(en, ud, ld, din, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
